triangle_scheduler: RTL and testbench
=====================================

Name: triangle_scheduler

Overview:
- Frame-level sequencer for draw_triangle.
- On frame_start it walks a triangle table (synchronous ROM/RAM, one entry per triangle, three screen-space vertices) from index 0 to tri_count-1.
- For each entry it loads V1/V2/V3, runs one draw_triangle start/done handshake, and signals frame_done after the last triangle.
- Sits between the frame/buffer-swap control and the draw_triangle → draw_line datapath.

Parameters:
- IDX_W, 8, triangle index width (table depth 2^IDX_W).
- COORD_W, 10, vertex coordinate width.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle request to render one frame; sampled only in IDLE.
- tri_count  in  IDX_W+1  number of triangles; latched on accepted frame_start.
- tri_addr  out  IDX_W  table read address.
- tri_rden  out  1  table read enable.
- tri_data  in  6*COORD_W  {V3.y,V3.x,V2.y,V2.x,V1.y,V1.x}; valid the cycle after tri_rden.
- V1, V2, V3  out  [1:0][COORD_W-1:0]  vertex to draw_triangle; [0]=x, [1]=y.
- draw_triangle_start  out  1  level request to draw_triangle.
- draw_triangle_done  in  1  completion from draw_triangle.
- busy  out  1  high from accepted frame_start until frame_done inclusive.
- frame_done  out  1  single-cycle pulse, frame complete.
- tri_skipped  out  IDX_W+1  triangles rejected this frame.

Behaviour:
- Reset (async, immediate): state=IDLE, idx=0. All outputs 0: tri_addr, tri_rden, V1–V3, draw_triangle_start, busy, frame_done, tri_skipped. Reset mid-frame abandons the frame; no frame_done. draw_triangle shares the same Reset.
- States: IDLE, FETCH, LATCH, DRAW, RELEASE, NEXT, FINISH.
- IDLE:
  - On frame_start=1: latch tri_count, clear idx and tri_skipped, busy←1.
  - If latched count=0 → FINISH; else → FETCH.
  - frame_start in any other state is ignored (not queued).
- FETCH (1 cycle): tri_rden=1, tri_addr=idx → LATCH.
- LATCH (1 cycle): register tri_data into V1/V2/V3.
  - Clip test on raw tri_data: any x ≥ 640 or any y ≥ 480 → tri_skipped+1 → NEXT.
  - Otherwise → DRAW.
- DRAW: draw_triangle_start=1; V regs held stable. On draw_triangle_done=1 → RELEASE with start=0 that same edge.
- RELEASE: start=0. Wait until draw_triangle_done=0 (minimum 1 cycle) → NEXT. A done held high never causes a second start.
- NEXT (1 cycle): if idx = count-1 → FINISH; else idx+1 → FETCH.
- FINISH (1 cycle): frame_done=1 → IDLE. busy drops the cycle after frame_done.
- Latency:
  - frame_start sampled at edge 0 → tri_rden high cycle 1 → V valid and start high cycle 3.
  - Per-triangle overhead outside draw_triangle is 4 cycles (FETCH, LATCH, RELEASE≥1, NEXT).
  - count=0: frame_done in cycle 1.
- Widths: idx compares against the latched count using unsigned IDX_W+1 arithmetic. count = 2^IDX_W is legal: the last address is all-ones and idx does not wrap before FINISH. tri_skipped saturates at count by construction.
- V1–V3 retain the last loaded triangle after the frame.

Decomposition:
- Shared package render_pkg:
  - COORD_W, SCREEN_W=640, SCREEN_H=480.
  - typedef vertex_t = logic [1:0][COORD_W-1:0].
  - typedef tri_t = vertex_t [2:0].
- Scheduler state enum is local to the module.
- No sub-module inside the scheduler. Triangle table is external (tri_rom, 1-cycle synchronous read); the bench uses a behavioural model.

Test Plan:
- Reset, frame_start, count=1, entry0 = V1(20,20) V2(40,20) V3(20,40); done model responds 10 cycles after start → tri_rden/tri_addr=0 in cycle 1, V values and start=1 in cycle 3, exactly one frame_done pulse, busy low afterwards, tri_skipped=0.
- count=3, distinct entries → addresses 0,1,2 in order; three start assertions, each with matching V1–V3; one frame_done.
- count=0 → frame_done in cycle 1; tri_rden and draw_triangle_start never asserted.
- count=3, entry1 has V2.x=640 → entry1 never started, tri_skipped=1, entries 0 and 2 drawn.
- Done held high 5 cycles; frame_start pulsed while busy → no re-start until done falls; second frame_start ignored, single frame_done.
- Reset asserted during DRAW → all outputs 0 immediately, no frame_done; a new frame_start after release runs normally from index 0.

Source files
------------

// File: rtl/render_pkg.sv
// Shared rendering types and screen limits.
// Used by the frame sequencer and the draw datapath.
package render_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // [0]=x, [1]=y
  typedef logic [1:0][COORD_W-1:0] vertex_t;
  // [0]=V1, [1]=V2, [2]=V3
  typedef vertex_t [2:0] tri_t;

endpackage

// File: rtl/triangle_scheduler.sv
// Frame sequencer: walks the triangle table and hands each
// on-screen triangle to draw_triangle, then pulses frame_done.
// Ports: Clk/Reset (async, active high); frame_start/tri_count
// request a frame; tri_addr/tri_rden/tri_data read the table
// (1-cycle latency); V1..V3 + draw_triangle_start/done form the
// draw handshake; busy, frame_done, tri_skipped report status.
module triangle_scheduler #(
  parameter int IDX_W   = 8,
  parameter int COORD_W = 10
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_start,
  input  logic [IDX_W:0]                tri_count,
  output logic [IDX_W-1:0]              tri_addr,
  output logic                          tri_rden,
  input  logic [6*COORD_W-1:0]          tri_data,
  output logic [1:0][COORD_W-1:0]       V1,
  output logic [1:0][COORD_W-1:0]       V2,
  output logic [1:0][COORD_W-1:0]       V3,
  output logic                          draw_triangle_start,
  input  logic                          draw_triangle_done,
  output logic                          busy,
  output logic                          frame_done,
  output logic [IDX_W:0]                tri_skipped
);

  import render_pkg::*;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    DRAW,
    RELEASE,
    NEXT,
    FINISH
  } state_t;

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);

  state_t state;

  logic [IDX_W:0] idx;
  logic [IDX_W:0] count;
  logic [IDX_W:0] idx_nxt;
  logic [IDX_W:0] last_idx;

  logic [2:0][1:0][COORD_W-1:0] raw;
  logic clip;

  assign raw      = tri_data;
  assign idx_nxt  = idx + 1'b1;
  assign last_idx = count - 1'b1;

  // Clip on the raw table word so the decision is made in LATCH.
  always_comb begin
    clip = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (raw[i][0] >= X_LIM || raw[i][1] >= Y_LIM)
        clip = 1'b1;
    end
  end

  // Outputs are registered: each transition also sets the
  // outputs that belong to the state being entered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state               <= IDLE;
      idx                 <= '0;
      count               <= '0;
      tri_addr            <= '0;
      tri_rden            <= 1'b0;
      V1                  <= '0;
      V2                  <= '0;
      V3                  <= '0;
      draw_triangle_start <= 1'b0;
      busy                <= 1'b0;
      frame_done          <= 1'b0;
      tri_skipped         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            count       <= tri_count;
            idx         <= '0;
            tri_skipped <= '0;
            busy        <= 1'b1;
            if (tri_count == '0) begin
              frame_done <= 1'b1;
              state      <= FINISH;
            end else begin
              tri_rden <= 1'b1;
              tri_addr <= '0;
              state    <= FETCH;
            end
          end
        end
        FETCH: begin
          tri_rden <= 1'b0;
          state    <= LATCH;
        end
        LATCH: begin
          V1 <= raw[0];
          V2 <= raw[1];
          V3 <= raw[2];
          if (clip) begin
            tri_skipped <= tri_skipped + 1'b1;
            state       <= NEXT;
          end else begin
            draw_triangle_start <= 1'b1;
            state               <= DRAW;
          end
        end
        DRAW: begin
          if (draw_triangle_done) begin
            draw_triangle_start <= 1'b0;
            state               <= RELEASE;
          end
        end
        RELEASE: begin
          // A lingering done must fall before we move on.
          if (!draw_triangle_done)
            state <= NEXT;
        end
        NEXT: begin
          if (idx == last_idx) begin
            frame_done <= 1'b1;
            state      <= FINISH;
          end else begin
            idx      <= idx_nxt;
            tri_addr <= idx_nxt[IDX_W-1:0];
            tri_rden <= 1'b1;
            state    <= FETCH;
          end
        end
        FINISH: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_scheduler.sv
// Directed bench for triangle_scheduler with a behavioural
// table ROM and a draw_triangle done responder.
module tb_triangle_scheduler;

  localparam int IDX_W = 8;
  localparam int CW    = 10;

  logic                    Clk;
  logic                    Reset;
  logic                    frame_start;
  logic [IDX_W:0]          tri_count;
  logic [IDX_W-1:0]        tri_addr;
  logic                    tri_rden;
  logic [6*CW-1:0]         tri_data;
  logic [1:0][CW-1:0]      V1;
  logic [1:0][CW-1:0]      V2;
  logic [1:0][CW-1:0]      V3;
  logic                    draw_triangle_start;
  logic                    draw_triangle_done;
  logic                    busy;
  logic                    frame_done;
  logic [IDX_W:0]          tri_skipped;

  triangle_scheduler #(.IDX_W(IDX_W), .COORD_W(CW)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .frame_start         (frame_start),
    .tri_count           (tri_count),
    .tri_addr            (tri_addr),
    .tri_rden            (tri_rden),
    .tri_data            (tri_data),
    .V1                  (V1),
    .V2                  (V2),
    .V3                  (V3),
    .draw_triangle_start (draw_triangle_start),
    .draw_triangle_done  (draw_triangle_done),
    .busy                (busy),
    .frame_done          (frame_done),
    .tri_skipped         (tri_skipped)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [6*CW-1:0] rom [0:(1<<IDX_W)-1];

  always @(posedge Clk)
    if (tri_rden) tri_data <= rom[tri_addr];

  int done_delay;
  int done_hold;
  int dm_phase;
  int dm_cnt;

  // done responder: rises done_delay cycles after start,
  // holds for done_hold cycles.
  initial begin
    draw_triangle_done = 1'b0;
    dm_phase = 0;
    dm_cnt   = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        draw_triangle_done = 1'b0;
        dm_phase = 0;
        dm_cnt   = 0;
      end else if (dm_phase == 0) begin
        if (draw_triangle_start) begin
          dm_cnt   = 1;
          dm_phase = 1;
        end
      end else if (dm_phase == 1) begin
        if (dm_cnt >= done_delay) begin
          draw_triangle_done = 1'b1;
          dm_cnt   = 1;
          dm_phase = 2;
        end else dm_cnt++;
      end else begin
        if (dm_cnt >= done_hold) begin
          draw_triangle_done = 1'b0;
          dm_phase = 0;
        end else dm_cnt++;
      end
    end
  end

  logic [6*CW-1:0]  start_log[$];
  logic [IDX_W-1:0] addr_log[$];
  int               fd_cnt;
  int               rden_cnt;
  logic             prev_start;

  always @(negedge Clk) begin
    if (draw_triangle_start && !prev_start)
      start_log.push_back({V3, V2, V1});
    if (tri_rden) begin
      addr_log.push_back(tri_addr);
      rden_cnt++;
    end
    if (frame_done) fd_cnt++;
    prev_start = draw_triangle_start;
  end

  int checks;
  int passes;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [6*CW-1:0] ent(
    input int x1, input int y1, input int x2,
    input int y2, input int x3, input int y3);
    return {CW'(y3), CW'(x3), CW'(y2), CW'(x2),
            CW'(y1), CW'(x1)};
  endfunction

  task automatic clear_logs();
    @(posedge Clk);
    #1;
    start_log.delete();
    addr_log.delete();
    fd_cnt   = 0;
    rden_cnt = 0;
  endtask

  // Leaves the bench just after edge 0 (frame_start sampled).
  task automatic launch(input int cnt);
    clear_logs();
    @(negedge Clk);
    tri_count   = (IDX_W+1)'(cnt);
    frame_start = 1'b1;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (!busy) break;
    end
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    prev_start  = 1'b0;
    fd_cnt      = 0;
    rden_cnt    = 0;
    frame_start = 1'b0;
    tri_count   = '0;
    tri_data    = '0;
    done_delay  = 10;
    done_hold   = 1;
    for (int i = 0; i < (1 << IDX_W); i++) rom[i] = '0;
    rom[0] = ent(20, 20, 40, 20, 20, 40);
    rom[1] = ent(100, 50, 200, 60, 150, 170);
    rom[2] = ent(639, 479, 0, 0, 300, 400);

    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rden", {63'd0, tri_rden}, 64'd0);
    check("rst_v", {4'd0, V3, V2, V1}, 64'd0);
    check("rst_skip", {55'd0, tri_skipped}, 64'd0);
    Reset = 1'b0;

    // Single triangle, latency profile.
    launch(1);
    @(negedge Clk);
    check("t1_rden_c1", {63'd0, tri_rden}, 64'd1);
    check("t1_addr_c1", {56'd0, tri_addr}, 64'd0);
    check("t1_busy_c1", {63'd0, busy}, 64'd1);
    @(negedge Clk);
    check("t1_start_c2", {63'd0, draw_triangle_start}, 64'd0);
    @(negedge Clk);
    check("t1_start_c3", {63'd0, draw_triangle_start}, 64'd1);
    check("t1_v1", {44'd0, V1}, {44'd0, 10'd20, 10'd20});
    check("t1_v2", {44'd0, V2}, {44'd0, 10'd20, 10'd40});
    check("t1_v3", {44'd0, V3}, {44'd0, 10'd40, 10'd20});
    wait_idle("t1_idle");
    check("t1_fd", 64'(fd_cnt), 64'd1);
    check("t1_starts", 64'(start_log.size()), 64'd1);
    check("t1_skip", {55'd0, tri_skipped}, 64'd0);
    check("t1_v_kept", {4'd0, V3, V2, V1}, {4'd0, rom[0]});

    // Three triangles, in order.
    done_delay = 3;
    launch(3);
    wait_idle("t2_idle");
    check("t2_nrd", 64'(addr_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < addr_log.size(); i++)
      check("t2_addr", {56'd0, addr_log[i]}, 64'(i));
    check("t2_nst", 64'(start_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < start_log.size(); i++)
      check("t2_vtx", {4'd0, start_log[i]}, {4'd0, rom[i]});
    check("t2_fd", 64'(fd_cnt), 64'd1);

    // Empty frame.
    launch(0);
    @(negedge Clk);
    check("t3_fd_c1", {63'd0, frame_done}, 64'd1);
    check("t3_busy_c1", {63'd0, busy}, 64'd1);
    @(negedge Clk);
    check("t3_busy_c2", {63'd0, busy}, 64'd0);
    check("t3_fd_c2", {63'd0, frame_done}, 64'd0);
    repeat (3) @(negedge Clk);
    check("t3_rden", 64'(rden_cnt), 64'd0);
    check("t3_nst", 64'(start_log.size()), 64'd0);
    check("t3_fd", 64'(fd_cnt), 64'd1);

    // Entry 1 off-screen (V2.x = 640).
    rom[1] = ent(100, 50, 640, 60, 150, 170);
    launch(3);
    wait_idle("t4_idle");
    check("t4_skip", {55'd0, tri_skipped}, 64'd1);
    check("t4_nrd", 64'(addr_log.size()), 64'd3);
    check("t4_nst", 64'(start_log.size()), 64'd2);
    if (start_log.size() == 2) begin
      check("t4_st0", {4'd0, start_log[0]}, {4'd0, rom[0]});
      check("t4_st1", {4'd0, start_log[1]}, {4'd0, rom[2]});
    end
    check("t4_fd", 64'(fd_cnt), 64'd1);

    // Long done, second frame_start while busy.
    done_delay = 2;
    done_hold  = 5;
    launch(1);
    repeat (4) @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    wait_idle("t5_idle");
    repeat (12) @(negedge Clk);
    check("t5_nst", 64'(start_log.size()), 64'd1);
    check("t5_fd", 64'(fd_cnt), 64'd1);
    check("t5_nrd", 64'(rden_cnt), 64'd1);
    check("t5_busy", {63'd0, busy}, 64'd0);

    // Reset in DRAW.
    done_delay = 10;
    done_hold  = 1;
    launch(3);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (draw_triangle_start) break;
    end
    check("t6_in_draw", {63'd0, draw_triangle_start}, 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("t6_rst_start", {63'd0, draw_triangle_start}, 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_v", {4'd0, V3, V2, V1}, 64'd0);
    check("t6_rst_addr", {55'd0, tri_addr, tri_rden}, 64'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (15) @(negedge Clk);
    check("t6_no_fd", 64'(fd_cnt), 64'd0);
    launch(1);
    wait_idle("t6_idle");
    check("t6_addr0", 64'(addr_log.size()), 64'd1);
    if (addr_log.size() == 1)
      check("t6_a0", {56'd0, addr_log[0]}, 64'd0);
    check("t6_nst", 64'(start_log.size()), 64'd1);
    if (start_log.size() == 1)
      check("t6_vtx", {4'd0, start_log[0]}, {4'd0, rom[0]});
    check("t6_fd", 64'(fd_cnt), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
